// File: rtl/tas_pkg.sv
// tas_pkg: shared definitions for the multi-channel packet averager.
//   HDR_TAG      : upper nibble that marks a header word
//   tas_state_t  : packet FSM state encoding
//   width_of()   : log2 width helper that never returns 0
//   region_top() : highest RAM address of a channel's region
`timescale 1ns/1ps
package tas_pkg;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WRITE    = 2'd2,
    WR_PULSE = 2'd3
  } tas_state_t;

  // Bits needed to index n items; a single item still gets a 1-bit field.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Each channel owns 2**addr_w/num_ch consecutive addresses and fills them top-down.
  function automatic int region_top(input int ch, input int addr_w, input int num_ch);
    return ((ch + 1) * ((1 << addr_w) / num_ch)) - 1;
  endfunction

endpackage

// File: rtl/tas_deser.sv
// tas_deser: serial-to-parallel word deserialiser.
// Ports:
//   clk_50, reset_n       : clock, asynchronous active-low reset
//   bit_strobe            : serial_data valid this cycle
//   serial_data           : serial bit, MSB first
//   data_ena              : word frame, high across all DATA_W strobes
//   word / word_vld       : completed word, valid for one cycle after its last bit
//   frame_err             : one-cycle pulse when a frame closes on a partial word
`timescale 1ns/1ps
module tas_deser #(
  parameter int DATA_W = 8
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              bit_strobe,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic [DATA_W-1:0] word,
  output logic              word_vld,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  bitcnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] word_reg;
  logic              vld_reg;
  logic              err_reg;
  logic              ena_d_reg;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_reg <= '0;
      shift_reg  <= '0;
      word_reg   <= '0;
      vld_reg    <= 1'b0;
      err_reg    <= 1'b0;
      ena_d_reg  <= 1'b0;
    end else begin
      vld_reg   <= 1'b0;
      err_reg   <= 1'b0;
      ena_d_reg <= data_ena;
      if (bit_strobe && data_ena) begin
        shift_reg <= {shift_reg[DATA_W-2:0], serial_data};
        if (bitcnt_reg == CNT_W'(DATA_W - 1)) begin
          // Last bit: publish the word directly so word_vld lands one cycle later.
          bitcnt_reg <= '0;
          word_reg   <= {shift_reg[DATA_W-2:0], serial_data};
          vld_reg    <= 1'b1;
        end else begin
          bitcnt_reg <= bitcnt_reg + 1'b1;
        end
      end else if (ena_d_reg && !data_ena && (bitcnt_reg != '0)) begin
        // Frame closed mid-word: drop the partial bits.
        bitcnt_reg <= '0;
        err_reg    <= 1'b1;
      end
    end
  end

  assign word      = word_reg;
  assign word_vld  = vld_reg;
  assign frame_err = err_reg;

endmodule

// File: rtl/tas_mc_avg.sv
// tas_mc_avg: multi-channel serial packet averager.
// A packet is a header {HDR_TAG, ch} followed by N_SAMPLES data words. The
// average of the data words is written to channel ch's RAM region, which is
// filled downward from its top address and wraps back to the top after the base.
// Ports:
//   clk_50, reset_n                 : clock, asynchronous active-low reset
//   bit_strobe, serial_data,
//   data_ena                        : serial link input
//   ram_wr_n, ram_data, ram_addr    : RAM write port (ram_wr_n active low, one cycle)
//   pkt_err                         : one-cycle pulse on a discarded word or packet
//   busy                            : high from a valid header until its write completes
// Build option: define TAS_ROUND_EN for a rounded, saturated average instead
// of the truncating one.
`timescale 1ns/1ps
module tas_mc_avg
  import tas_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_SAMPLES = 4,
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 11
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              bit_strobe,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              pkt_err,
  output logic              busy
);

  localparam int LOG2N  = $clog2(N_SAMPLES);
  localparam int SUM_W  = DATA_W + LOG2N;
  localparam int CH_W   = width_of(NUM_CH);
  localparam int CHF_W  = DATA_W - 4;
  localparam int REGION = (1 << ADDR_W) / NUM_CH;
  localparam logic [ADDR_W-1:0] TOP0     = ADDR_W'(region_top(0, ADDR_W, NUM_CH));
  localparam logic [CHF_W:0]    NUM_CH_V = (CHF_W + 1)'(NUM_CH);

  // Deserialiser
  logic [DATA_W-1:0] deser_word;
  logic              deser_vld;
  logic              deser_err;

  tas_deser #(.DATA_W(DATA_W)) u_deser (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .bit_strobe  (bit_strobe),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .word        (deser_word),
    .word_vld    (deser_vld),
    .frame_err   (deser_err)
  );

  // Average of a full packet sum
  function automatic logic [DATA_W-1:0] avg_of(input logic [SUM_W-1:0] s);
`ifdef TAS_ROUND_EN
    logic [SUM_W:0] r;
    r = ({1'b0, s} + (SUM_W + 1)'(N_SAMPLES / 2)) >> LOG2N;
    if (r > (SUM_W + 1)'((1 << DATA_W) - 1)) return '1;
    return r[DATA_W-1:0];
`else
    logic [SUM_W-1:0] q;
    q = s >> LOG2N;
    return q[DATA_W-1:0];
`endif
  endfunction

  // State
  tas_state_t        state_reg, state_next;
  logic [SUM_W-1:0]  sum_reg, sum_next;
  logic [LOG2N-1:0]  cnt_reg, cnt_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic              busy_reg, busy_next;
  logic              wr_n_reg, wr_n_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              err_reg, err_next;
  logic              hold_vld_reg, hold_vld_next;
  logic [DATA_W-1:0] hold_word_reg, hold_word_next;

  logic              cur_vld;
  logic [DATA_W-1:0] cur_word;
  logic              hdr_ok;
  logic [SUM_W-1:0]  sum_add;
  logic              ptr_dec;
  logic [ADDR_W-1:0] ptr_all [NUM_CH];

  // Per-channel write pointers
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ptr
    localparam logic [ADDR_W-1:0] TOP   = ADDR_W'(region_top(gi, ADDR_W, NUM_CH));
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(gi * REGION);
    localparam logic [CH_W-1:0]   MY_CH = CH_W'(gi);
    logic [ADDR_W-1:0] ptr_reg;

    always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
        ptr_reg <= TOP;
      end else if (ptr_dec && (ch_reg == MY_CH)) begin
        ptr_reg <= (ptr_reg == BASE) ? TOP : ptr_reg - 1'b1;
      end
    end

    assign ptr_all[gi] = ptr_reg;
  end

  // FSM state and datapath registers
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      ch_reg        <= '0;
      busy_reg      <= 1'b0;
      wr_n_reg      <= 1'b1;
      data_reg      <= '0;
      addr_reg      <= TOP0;
      err_reg       <= 1'b0;
      hold_vld_reg  <= 1'b0;
      hold_word_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sum_reg       <= sum_next;
      cnt_reg       <= cnt_next;
      ch_reg        <= ch_next;
      busy_reg      <= busy_next;
      wr_n_reg      <= wr_n_next;
      data_reg      <= data_next;
      addr_reg      <= addr_next;
      err_reg       <= err_next;
      hold_vld_reg  <= hold_vld_next;
      hold_word_reg <= hold_word_next;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next     = state_reg;
    sum_next       = sum_reg;
    cnt_next       = cnt_reg;
    ch_next        = ch_reg;
    busy_next      = busy_reg;
    wr_n_next      = 1'b1;
    data_next      = data_reg;
    addr_next      = addr_reg;
    err_next       = deser_err;
    hold_vld_next  = hold_vld_reg;
    hold_word_next = hold_word_reg;
    ptr_dec        = 1'b0;

    // A held word is always older than a fresh one, so it is consumed first.
    cur_vld  = hold_vld_reg || deser_vld;
    cur_word = hold_vld_reg ? hold_word_reg : deser_word;
    hdr_ok   = (cur_word[DATA_W-1 -: 4] == HDR_TAG) &&
               ({1'b0, cur_word[CHF_W-1:0]} < NUM_CH_V);
    sum_add  = sum_reg + SUM_W'(cur_word);

    case (state_reg)
      IDLE: begin
        if (cur_vld) begin
          if (hold_vld_reg) begin
            hold_vld_next  = deser_vld;
            hold_word_next = deser_word;
          end
          if (hdr_ok) begin
            state_next = ACCUM;
            ch_next    = cur_word[CH_W-1:0];
            sum_next   = '0;
            cnt_next   = '0;
            busy_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (deser_err) begin
          state_next = IDLE;
          sum_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end else if (cur_vld) begin
          if (hold_vld_reg) begin
            hold_vld_next  = deser_vld;
            hold_word_next = deser_word;
          end
          sum_next = sum_add;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LOG2N'(N_SAMPLES - 1)) begin
            // Result and address are registered here so they are stable a
            // full cycle before the write strobe.
            state_next = WRITE;
            data_next  = avg_of(sum_add);
            addr_next  = ptr_all[ch_reg];
          end
        end
      end

      WRITE, WR_PULSE: begin
        if (state_reg == WRITE) begin
          wr_n_next  = 1'b0;
          state_next = WR_PULSE;
        end else begin
          busy_next  = 1'b0;
          ptr_dec    = 1'b1;
          state_next = IDLE;
        end
        if (deser_vld) begin
          if (hold_vld_reg) begin
            err_next = 1'b1;
          end else begin
            hold_vld_next  = 1'b1;
            hold_word_next = deser_word;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign ram_wr_n = wr_n_reg;
  assign ram_data = data_reg;
  assign ram_addr = addr_reg;
  assign pkt_err  = err_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_tas_mc_avg.sv
// tb_tas_mc_avg: directed and randomised check of tas_mc_avg.
// Two instances share one serial stream: dut_a with default parameters and
// dut_b with a 16-word RAM (8 words per channel) so region wrap-around is
// reached after a handful of packets. Build option TAS_ROUND_EN selects the
// rounded expected average.
`timescale 1ns/1ps
module tb_tas_mc_avg;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_strobe = 1'b0;
  logic        serial_data = 1'b0;
  logic        data_ena = 1'b0;

  logic        wr_n_a, err_a, busy_a;
  logic [7:0]  data_a;
  logic [10:0] addr_a;
  logic        wr_n_b, err_b, busy_b;
  logic [7:0]  data_b;
  logic [3:0]  addr_b;

  always #10 clk_50 = ~clk_50;

  tas_mc_avg dut_a (
    .clk_50(clk_50), .reset_n(reset_n), .bit_strobe(bit_strobe),
    .serial_data(serial_data), .data_ena(data_ena),
    .ram_wr_n(wr_n_a), .ram_data(data_a), .ram_addr(addr_a),
    .pkt_err(err_a), .busy(busy_a)
  );

  tas_mc_avg #(.ADDR_W(4)) dut_b (
    .clk_50(clk_50), .reset_n(reset_n), .bit_strobe(bit_strobe),
    .serial_data(serial_data), .data_ena(data_ena),
    .ram_wr_n(wr_n_b), .ram_data(data_b), .ram_addr(addr_b),
    .pkt_err(err_b), .busy(busy_b)
  );

  localparam int REG_A = 1024;
  localparam int REG_B = 8;

  int total = 0;
  int bad   = 0;

  // Observed writes, recorded on the falling edge
  int wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int low_run_a = 0, low_run_b = 0, long_low = 0;
  int errs_a = 0, errs_b = 0, busy_cnt_a = 0;

  always @(negedge clk_50) begin
    if (!wr_n_a) begin
      wa_addr.push_back(int'(addr_a));
      wa_data.push_back(int'(data_a));
      low_run_a++;
      if (low_run_a > 1) long_low++;
    end else begin
      low_run_a = 0;
    end
    if (!wr_n_b) begin
      wb_addr.push_back(int'(addr_b));
      wb_data.push_back(int'(data_b));
      low_run_b++;
      if (low_run_b > 1) long_low++;
    end else begin
      low_run_b = 0;
    end
    if (err_a) errs_a++;
    if (err_b) errs_b++;
    if (busy_a) busy_cnt_a++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: channel ch's k-th write (from 0) goes k steps below
  // its region top, modulo the region size.
  int cnt_a[2], cnt_b[2];
  int rd_a = 0, rd_b = 0;

  function automatic int exp_addr(input int ch, input int k, input int region);
    return ch * region + (region - 1) - (k % region);
  endfunction

  function automatic int ref_avg(input int s);
    int r;
`ifdef TAS_ROUND_EN
    r = (s + 2) / 4;
    if (r > 255) r = 255;
`else
    r = s / 4;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits);
    data_ena = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_50);
      serial_data = w[7-i];
      bit_strobe  = 1'b1;
      @(negedge clk_50);
      bit_strobe = 1'b0;
      @(negedge clk_50);
    end
    @(negedge clk_50);
    data_ena = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int s0, input int s1,
                          input int s2, input int s3);
    send_word(hdr, 8);
    send_word(8'(s0), 8);
    send_word(8'(s1), 8);
    send_word(8'(s2), 8);
    send_word(8'(s3), 8);
    repeat (6) @(negedge clk_50);
  endtask

  task automatic expect_write(input int ch, input int sum);
    chk("nwr_a", wa_addr.size() - rd_a, 1);
    chk("nwr_b", wb_addr.size() - rd_b, 1);
    if (wa_addr.size() > rd_a) begin
      chk("addr_a", wa_addr[rd_a], exp_addr(ch, cnt_a[ch], REG_A));
      chk("data_a", wa_data[rd_a], ref_avg(sum));
    end
    if (wb_addr.size() > rd_b) begin
      chk("addr_b", wb_addr[rd_b], exp_addr(ch, cnt_b[ch], REG_B));
      chk("data_b", wb_data[rd_b], ref_avg(sum));
    end
    rd_a = wa_addr.size();
    rd_b = wb_addr.size();
    cnt_a[ch]++;
    cnt_b[ch]++;
  endtask

  task automatic expect_none(input string tag);
    chk(tag, (wa_addr.size() - rd_a) + (wb_addr.size() - rd_b), 0);
    rd_a = wa_addr.size();
    rd_b = wb_addr.size();
  endtask

  task automatic rand_pkt(input int ch);
    int s0, s1, s2, s3;
    s0 = int'($urandom_range(0, 255));
    s1 = int'($urandom_range(0, 255));
    s2 = int'($urandom_range(0, 255));
    s3 = int'($urandom_range(0, 255));
    send_pkt(8'hA0 | 8'(ch), s0, s1, s2, s3);
    expect_write(ch, s0 + s1 + s2 + s3);
  endtask

  initial begin
    int e0, b0, s;
    cnt_a = '{0, 0};
    cnt_b = '{0, 0};

    // Reset state
    repeat (3) @(negedge clk_50);
    chk("rst_wr_n", wr_n_a, 1);
    chk("rst_data", data_a, 0);
    chk("rst_addr_a", addr_a, 11'h3FF);
    chk("rst_addr_b", addr_b, 4'h7);
    chk("rst_err", err_a, 0);
    chk("rst_busy", busy_a, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);

    // Basic packet
    b0 = busy_cnt_a;
    send_pkt(8'hA1, 10, 20, 30, 42);
    expect_write(1, 102);
    chk("basic_addr_0x7ff", addr_a, 11'h7FF);
    chk("wr_pulse_len", long_low, 0);
    chk("busy_seen", busy_cnt_a > b0, 1);
    chk("busy_after", busy_a, 0);

    // Interleaved channels, random samples
    for (int p = 0; p < 3; p++) begin
      rand_pkt(0);
      rand_pkt(1);
    end

    // Bad headers
    e0 = errs_a;
    b0 = busy_cnt_a;
    send_word(8'hC3, 8);
    repeat (4) @(negedge clk_50);
    chk("err_c3", errs_a - e0, 1);
    send_word(8'hA7, 8);
    repeat (4) @(negedge clk_50);
    chk("err_a7", errs_a - e0, 2);
    chk("err_b_hdr", errs_b - e0, 2);
    chk("bad_hdr_busy", busy_cnt_a - b0, 0);
    expect_none("bad_hdr_nowr");

    // Frame error during second sample
    e0 = errs_a;
    send_word(8'hA0, 8);
    send_word(8'd55, 8);
    send_word(8'd66, 5);
    repeat (6) @(negedge clk_50);
    chk("frame_err", errs_a - e0, 1);
    chk("frame_busy", busy_a, 0);
    expect_none("frame_nowr");
    send_pkt(8'hA0, 1, 2, 3, 250);
    expect_write(0, 256);

    // Wrap in the small instance, then check channel 0 is untouched
    for (int p = 0; p < 10; p++) rand_pkt(1);
    rand_pkt(0);
    send_pkt(8'hA1, 255, 255, 255, 255);
    expect_write(1, 1020);

    // Reset in the middle of a packet
    send_word(8'hA0, 8);
    send_word(8'd200, 8);
    send_word(8'd201, 8);
    @(negedge clk_50);
    reset_n = 1'b0;
    @(negedge clk_50);
    chk("mid_rst_wr_n", wr_n_a, 1);
    chk("mid_rst_addr", addr_a, 11'h3FF);
    chk("mid_rst_data", data_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    @(negedge clk_50);
    reset_n = 1'b1;
    cnt_a = '{0, 0};
    cnt_b = '{0, 0};
    expect_none("mid_rst_nowr");
    s = 7 + 9 + 11 + 13;
    send_pkt(8'hA1, 7, 9, 11, 13);
    expect_write(1, s);
    rand_pkt(0);
    chk("wr_pulse_len_end", long_low, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
